// File: rtl/rstn_seq_pkg.sv
// ============================================================================
//  Module      : rstn_seq_pkg
//  Description : Shared types, default parameters and width helper for the
//                reset-release sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rstn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int c_DEF_N_OUT       = 4;
    localparam int c_DEF_HOLD_CYCLES = 16;
    localparam int c_DEF_STAGE_GAP   = 4;
    localparam int c_DEF_FILT        = 3;

    // Counter must hold the larger of the two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rstn_req_filter.sv
// ============================================================================
//  Module      : rstn_req_filter
//  Description : Two-flop synchronizer and run-length filter for the external
//                reset request; emits a single-cycle accept per high run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rstn_req_filter
    import rstn_seq_pkg::*;
#(
    parameter int FILT = c_DEF_FILT
) (
    input  logic CK,
    input  logic R,
    input  logic REQ_EXT,
    output logic ACCEPT
);

    localparam int                 c_RUN_W   = $clog2(FILT + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(FILT);
    localparam logic [c_RUN_W-1:0] c_RUN_ARM = c_RUN_W'(FILT - 1);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_RUN_W-1:0] r_run;

    always_ff @(posedge CK) begin
        if (R) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_run   <= '0;
        end else begin
            r_sync1 <= REQ_EXT;
            r_sync2 <= r_sync1;
            // Saturating at FILT keeps a held-high request from re-accepting.
            if (!r_sync2) begin
                r_run <= '0;
            end else if (r_run != c_RUN_MAX) begin
                r_run <= r_run + c_RUN_ONE;
            end
        end
    end

    // Accept fires on the edge where the run count steps to FILT.
    assign ACCEPT = r_sync2 && (r_run == c_RUN_ARM);

endmodule

`default_nettype wire

// File: rtl/rstn_release_seq.sv
// ============================================================================
//  Module      : rstn_release_seq
//  Description : Merges power-on, external and software reset sources into a
//                hold-then-staggered-release sequence on active-low RN pins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rstn_release_seq
    import rstn_seq_pkg::*;
#(
    parameter int N_OUT       = c_DEF_N_OUT,
    parameter int HOLD_CYCLES = c_DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = c_DEF_STAGE_GAP,
    parameter int FILT        = c_DEF_FILT
) (
    input  logic             CK,
    input  logic             R,
    input  logic             REQ_EXT,
    input  logic             SW_REQ,
    output logic             SW_ACK,
    output logic [N_OUT-1:0] RN,
    output logic             BUSY
);

    localparam int                 c_CNT_W     = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int                 c_IDX_W     = $clog2(N_OUT + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(STAGE_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_OUT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_sw_pend;
    logic               r_sw_ack;
    logic               r_busy;
    logic [N_OUT-1:0]   r_rn;

    state_t             w_state;
    logic [c_CNT_W-1:0] w_cnt;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_sw_pend;
    logic               w_sw_ack;
    logic [N_OUT-1:0]   w_rn;
    logic [N_OUT-1:0]   w_idx_onehot;
    logic               w_accept;
    logic               w_trig;

    rstn_req_filter #(
        .FILT    (FILT)
    ) u_req_filter (
        .CK      (CK),
        .R       (R),
        .REQ_EXT (REQ_EXT),
        .ACCEPT  (w_accept)
    );

    assign w_trig = SW_REQ | w_accept;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_onehot
        assign w_idx_onehot[gi] = (r_idx == c_IDX_W'(gi));
    end

    always_ff @(posedge CK) begin
        if (R) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_sw_pend <= 1'b0;
            r_sw_ack  <= 1'b0;
            r_busy    <= 1'b1;
            r_rn      <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_sw_pend <= w_sw_pend;
            r_sw_ack  <= w_sw_ack;
            r_busy    <= ~&w_rn;
            r_rn      <= w_rn;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_sw_pend = r_sw_pend;
        w_sw_ack  = 1'b0;
        w_rn      = r_rn;

        // A trigger pre-empts completion, so sw_pend survives a collision.
        if (w_trig) begin
            w_state   = HOLD;
            w_cnt     = '0;
            w_idx     = '0;
            w_rn      = '0;
            w_sw_pend = r_sw_pend | SW_REQ;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_rn[0] = 1'b1;
                        w_cnt   = '0;
                        w_idx   = c_IDX_ONE;
                        if (N_OUT == 1) begin
                            w_state   = IDLE;
                            w_sw_ack  = r_sw_pend;
                            w_sw_pend = 1'b0;
                        end else begin
                            w_state = RELEASE;
                        end
                    end else begin
                        w_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_rn  = r_rn | w_idx_onehot;
                        w_idx = r_idx + c_IDX_ONE;
                        w_cnt = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_state   = IDLE;
                            w_sw_ack  = r_sw_pend;
                            w_sw_pend = 1'b0;
                        end
                    end else begin
                        w_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                IDLE: begin
                    w_rn = '1;
                end
                default: begin
                    w_state = HOLD;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_rn    = '0;
                end
            endcase
        end
    end

    assign RN     = r_rn;
    assign BUSY   = r_busy;
    assign SW_ACK = r_sw_ack;

endmodule

`default_nettype wire

// File: tb/tb_rstn_release_seq.sv
// ============================================================================
//  Module      : tb_rstn_release_seq
//  Description : Self-checking bench for rstn_release_seq: default instance
//                plus a single-bank minimum-timing instance on shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rstn_release_seq;

    localparam int A_N = 4, A_H = 16, A_G = 4, A_F = 3;
    localparam int B_N = 1, B_H = 1,  B_G = 1, B_F = 1;

    logic       CK = 1'b0;
    logic       R = 1'b1;
    logic       REQ_EXT = 1'b0;
    logic       SW_REQ = 1'b0;
    logic       a_ack, a_busy, b_ack, b_busy;
    logic [3:0] a_rn;
    logic [0:0] b_rn;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = -1;

    // Sampled REQ_EXT per edge; forced low where reset clears the synchronizer.
    bit hist[$];
    int t0[2];
    bit pend[2];
    bit ack_exp[2];

    always #5 CK = ~CK;

    rstn_release_seq #(.N_OUT(A_N), .HOLD_CYCLES(A_H), .STAGE_GAP(A_G), .FILT(A_F)) u_dut_a (
        .CK(CK), .R(R), .REQ_EXT(REQ_EXT), .SW_REQ(SW_REQ),
        .SW_ACK(a_ack), .RN(a_rn), .BUSY(a_busy)
    );

    rstn_release_seq #(.N_OUT(B_N), .HOLD_CYCLES(B_H), .STAGE_GAP(B_G), .FILT(B_F)) u_dut_b (
        .CK(CK), .R(R), .REQ_EXT(REQ_EXT), .SW_REQ(SW_REQ),
        .SW_ACK(b_ack), .RN(b_rn), .BUSY(b_busy)
    );

    // Accept at edge n: the synchronized samples form a high run of exactly filt.
    function automatic bit accepted(input int n, input int filt);
        int idx;
        for (int j = 0; j < filt; j++) begin
            idx = n - 2 - j;
            if (idx < 0) return 1'b0;
            if (!hist[idx]) return 1'b0;
        end
        idx = n - 2 - filt;
        if (idx >= 0 && hist[idx]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input int k, input int nn, input int hh, input int gg, input int ff);
        int total;
        total = hh + (nn - 1) * gg;
        ack_exp[k] = 1'b0;
        if (R) begin
            t0[k]   = edge_n;
            pend[k] = 1'b0;
        end else if (SW_REQ || accepted(edge_n, ff)) begin
            t0[k]   = edge_n;
            pend[k] = pend[k] | SW_REQ;
        end else if (edge_n - t0[k] == total) begin
            ack_exp[k] = pend[k];
            pend[k]    = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rn(input int k, input int nn, input int hh, input int gg);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nn; i++)
            if (edge_n - t0[k] >= hh + i * gg) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, expv);
        end
    endtask

    task automatic tick(input bit r, input bit sw, input bit req);
        logic [31:0] ea, eb;
        R       = r;
        SW_REQ  = sw;
        REQ_EXT = req;
        @(posedge CK);
        edge_n++;
        hist.push_back(r ? 1'b0 : req);
        if (r && edge_n >= 1) hist[edge_n - 1] = 1'b0;
        model_edge(0, A_N, A_H, A_G, A_F);
        model_edge(1, B_N, B_H, B_G, B_F);
        #1;
        ea = exp_rn(0, A_N, A_H, A_G);
        eb = exp_rn(1, B_N, B_H, B_G);
        chk("a_rn",   {28'd0, a_rn},   ea);
        chk("a_busy", {31'd0, a_busy}, {31'd0, (ea != 32'hF)});
        chk("a_ack",  {31'd0, a_ack},  {31'd0, ack_exp[0]});
        chk("b_rn",   {31'd0, b_rn},   eb);
        chk("b_busy", {31'd0, b_busy}, {31'd0, (eb != 32'h1)});
        chk("b_ack",  {31'd0, b_ack},  {31'd0, ack_exp[1]});
        @(negedge CK);
    endtask

    initial begin
        bit req_lvl;
        int req_left;
        t0[0] = 0; t0[1] = 0; pend[0] = 0; pend[1] = 0;

        // power-on
        repeat (3) tick(1, 0, 0);
        repeat (40) tick(0, 0, 0);
        // software handshake
        tick(0, 1, 0);
        repeat (35) tick(0, 0, 0);
        // 2-cycle glitch, then a 10-cycle held request
        tick(0, 0, 1); tick(0, 0, 1);
        repeat (10) tick(0, 0, 0);
        repeat (10) tick(0, 0, 1);
        repeat (40) tick(0, 0, 0);
        // restart with RN=0011
        tick(0, 1, 0);
        repeat (21) tick(0, 0, 0);
        tick(0, 1, 0);
        repeat (35) tick(0, 0, 0);
        // SW_REQ on the completion edge
        tick(0, 1, 0);
        repeat (27) tick(0, 0, 0);
        tick(0, 1, 0);
        repeat (35) tick(0, 0, 0);
        // R mid-release of a software sequence
        tick(0, 1, 0);
        repeat (22) tick(0, 0, 0);
        tick(1, 0, 0);
        repeat (35) tick(0, 0, 0);

        // random mix of all sources
        req_lvl  = 1'b0;
        req_left = 20;
        for (int i = 0; i < 1500; i++) begin
            if (req_left == 0) begin
                req_lvl  = ~req_lvl;
                req_left = $urandom_range(1, 12);
            end
            req_left--;
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), req_lvl);
        end
        repeat (40) tick(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
